// File: rtl/quad_seven_seg_pkg.sv
// quad_seven_seg_pkg: shared constants for the quad seven-segment driver
//   SEG_LUT          : active-low {g,f,e,d,c,b,a} patterns for hex 0..F
//   REFRESH_BITS_DEF : default refresh counter width
//   AN_OFF / AN_DIG  : anode patterns (all off / digit k selected)
package quad_seven_seg_pkg;
  localparam int REFRESH_BITS_DEF = 18;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] AN_DIG [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
endpackage

// File: rtl/quad_seven_seg_if.sv
// quad_seven_seg_if: user-side values/dots in, display pins and latched nibbles out
//   master : drives val0..3/dot0..3, observes anx/val/seg0..3
//   slave  : the driver itself
interface quad_seven_seg_if;
  logic [3:0] val0, val1, val2, val3;
  logic       dot0, dot1, dot2, dot3;
  logic [3:0] anx;
  logic [7:0] val;
  logic [3:0] seg0, seg1, seg2, seg3;
  modport master (
    output val0, val1, val2, val3, dot0, dot1, dot2, dot3,
    input  anx, val, seg0, seg1, seg2, seg3
  );
  modport slave (
    input  val0, val1, val2, val3, dot0, dot1, dot2, dot3,
    output anx, val, seg0, seg1, seg2, seg3
  );
endinterface

// File: rtl/quad_seven_seg_hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low {g..a} segment decoder
//   i_nib : 4-bit hex value
//   o_seg : 7-bit active-low segment pattern {g,f,e,d,c,b,a}
module hex_to_seg7
  import quad_seven_seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = SEG_LUT[i_nib];
endmodule

// File: rtl/quad_seven_seg.sv
// quad_seven_seg: 4-digit multiplexed common-anode seven-segment driver
//   clk   : system clock (100 MHz)
//   rst_n : asynchronous active-low reset
//   bus   : slave side of quad_seven_seg_if (values/dots in, anx/val/seg0..3 out)
module quad_seven_seg
  import quad_seven_seg_pkg::*;
#(
  parameter int REFRESH_BITS = REFRESH_BITS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  quad_seven_seg_if.slave  bus
);
  logic [REFRESH_BITS-1:0] r_cnt;
  logic [3:0][3:0]         r_nib;
  logic [3:0]              r_dot;
  logic [3:0]              r_anx;
  logic [7:0]              r_val;
  logic [1:0]              w_sel;
  logic [6:0]              w_seg;
  assign w_sel = r_cnt[REFRESH_BITS-1 -: 2];
  hex_to_seg7 u_dec (.i_nib(r_nib[w_sel]), .o_seg(w_seg));
  // cnt is 0 on the first clock after reset, so the live inputs are captured
  // immediately as well as at every frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_nib <= '0;
      r_dot <= '0;
      r_anx <= AN_OFF;
      r_val <= 8'hFF;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == '0) begin
        r_nib <= {bus.val3, bus.val2, bus.val1, bus.val0};
        r_dot <= {bus.dot3, bus.dot2, bus.dot1, bus.dot0};
      end
      r_anx <= AN_DIG[w_sel];
      r_val <= {~r_dot[w_sel], w_seg};
    end
  end
  assign bus.anx  = r_anx;
  assign bus.val  = r_val;
  assign bus.seg0 = r_nib[0];
  assign bus.seg1 = r_nib[1];
  assign bus.seg2 = r_nib[2];
  assign bus.seg3 = r_nib[3];
endmodule

// File: tb/tb_quad_seven_seg.sv
// tb_quad_seven_seg: directed self-checking bench for quad_seven_seg
module tb_quad_seven_seg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [6:0] lut [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  always #5 clk = ~clk;
  quad_seven_seg_if s_if ();
  quad_seven_seg_if b_if ();
  quad_seven_seg #(.REFRESH_BITS(4)) u_small (.clk(clk), .rst_n(rst_n), .bus(s_if));
  quad_seven_seg u_big (.clk(clk), .rst_n(rst_n), .bus(b_if));
  initial begin
    b_if.val3 = 4'h0; b_if.dot3 = 1'b0;
    b_if.val2 = 4'h1; b_if.dot2 = 1'b1;
    b_if.val1 = 4'h2; b_if.dot1 = 1'b0;
    b_if.val0 = 4'h3; b_if.dot0 = 1'b1;
  end
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (s_if.anx == 4'b0000 || $countones(~s_if.anx) > 1) begin
        errors++;
        $display("FAIL inv_small_anx got %b want at most one zero", s_if.anx);
      end
      checks++;
      if (b_if.anx == 4'b0000 || $countones(~b_if.anx) > 1) begin
        errors++;
        $display("FAIL inv_big_anx got %b want at most one zero", b_if.anx);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_pattern();
    s_if.val3 = 4'h0; s_if.dot3 = 1'b0;
    s_if.val2 = 4'h1; s_if.dot2 = 1'b1;
    s_if.val1 = 4'h2; s_if.dot1 = 1'b0;
    s_if.val0 = 4'h3; s_if.dot0 = 1'b1;
  endtask
  task automatic hold_reset();
    rst_n = 1'b0;
    tick(2);
  endtask
  task automatic test_reset();
    set_pattern();
    hold_reset();
    checks++;
    if ({s_if.anx, s_if.val} !== {4'b1111, 8'hFF}) begin
      errors++;
      $display("FAIL reset_out got %b/%h want 1111/ff", s_if.anx, s_if.val);
    end
    checks++;
    if ({s_if.seg3, s_if.seg2, s_if.seg1, s_if.seg0} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_seg got %h want 0000", {s_if.seg3, s_if.seg2, s_if.seg1, s_if.seg0});
    end
    checks++;
    if ({b_if.anx, b_if.val} !== {4'b1111, 8'hFF}) begin
      errors++;
      $display("FAIL reset_big got %b/%h want 1111/ff", b_if.anx, b_if.val);
    end
    rst_n = 1'b1;
    tick(1);
    checks++;
    if ({s_if.anx, s_if.val} !== {4'b1110, 8'hC0}) begin
      errors++;
      $display("FAIL release_first got %b/%h want 1110/c0", s_if.anx, s_if.val);
    end
    checks++;
    if (s_if.seg0 !== 4'h3) begin
      errors++;
      $display("FAIL release_latch got %h want 3", s_if.seg0);
    end
  endtask
  task automatic test_static();
    logic [3:0] an_exp [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [7:0] v_exp [5] = '{8'h30, 8'hA4, 8'h79, 8'hC0, 8'h30};
    int steps [5] = '{2, 3, 4, 4, 4};
    set_pattern();
    hold_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(steps[i]);
      checks++;
      if ({s_if.anx, s_if.val} !== {an_exp[i], v_exp[i]}) begin
        errors++;
        $display("FAIL static_step%0d got %b/%h want %b/%h", i, s_if.anx, s_if.val, an_exp[i], v_exp[i]);
      end
      if (i == 0) begin
        checks++;
        if ({b_if.anx, b_if.val} !== {4'b1110, 8'h30}) begin
          errors++;
          $display("FAIL big_first got %b/%h want 1110/30", b_if.anx, b_if.val);
        end
      end
    end
    tick(65536 - 17);
    checks++;
    if ({b_if.anx, b_if.val} !== {4'b1110, 8'h30}) begin
      errors++;
      $display("FAIL big_last_d0 got %b/%h want 1110/30", b_if.anx, b_if.val);
    end
    tick(1);
    checks++;
    if ({b_if.anx, b_if.val} !== {4'b1101, 8'hA4}) begin
      errors++;
      $display("FAIL big_first_d1 got %b/%h want 1101/a4", b_if.anx, b_if.val);
    end
  endtask
  task automatic test_decode();
    set_pattern();
    s_if.val0 = 4'h0;
    s_if.dot0 = 1'b0;
    hold_reset();
    rst_n = 1'b1;
    tick(2);
    for (int v = 0; v < 16; v++) begin
      if (v > 0) begin
        s_if.val0 = 4'(v);
        tick(16);
      end
      checks++;
      if ({s_if.anx, s_if.val} !== {4'b1110, 1'b1, lut[v]}) begin
        errors++;
        $display("FAIL decode_%h got %b/%h want 1110/%h", v[3:0], s_if.anx, s_if.val, {1'b1, lut[v]});
      end
    end
  endtask
  task automatic test_frame_latch();
    set_pattern();
    hold_reset();
    rst_n = 1'b1;
    tick(6);
    s_if.val1 = 4'h7;
    tick(2);
    checks++;
    if ({s_if.anx, s_if.val, s_if.seg1} !== {4'b1101, 8'hA4, 4'h2}) begin
      errors++;
      $display("FAIL latch_hold got %b/%h/%h want 1101/a4/2", s_if.anx, s_if.val, s_if.seg1);
    end
    tick(8);
    checks++;
    if (s_if.seg1 !== 4'h2) begin
      errors++;
      $display("FAIL latch_prewrap got %h want 2", s_if.seg1);
    end
    tick(1);
    checks++;
    if (s_if.seg1 !== 4'h7) begin
      errors++;
      $display("FAIL latch_wrap got %h want 7", s_if.seg1);
    end
    tick(4);
    checks++;
    if ({s_if.anx, s_if.val} !== {4'b1101, 8'hF8}) begin
      errors++;
      $display("FAIL latch_shown got %b/%h want 1101/f8", s_if.anx, s_if.val);
    end
  endtask
  task automatic test_async_reset();
    set_pattern();
    hold_reset();
    rst_n = 1'b1;
    tick(10);
    checks++;
    if (s_if.anx !== 4'b1011) begin
      errors++;
      $display("FAIL async_pre got %b want 1011", s_if.anx);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_if.anx, s_if.val, s_if.seg3, s_if.seg2, s_if.seg1, s_if.seg0} !== {4'b1111, 8'hFF, 16'h0000}) begin
      errors++;
      $display("FAIL async_reset got %b/%h/%h want 1111/ff/0000", s_if.anx, s_if.val,
               {s_if.seg3, s_if.seg2, s_if.seg1, s_if.seg0});
    end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    checks++;
    if ({s_if.anx, s_if.val} !== {4'b1110, 8'hC0}) begin
      errors++;
      $display("FAIL async_restart got %b/%h want 1110/c0", s_if.anx, s_if.val);
    end
    tick(1);
    checks++;
    if ({s_if.anx, s_if.val} !== {4'b1110, 8'h30}) begin
      errors++;
      $display("FAIL async_restart2 got %b/%h want 1110/30", s_if.anx, s_if.val);
    end
  endtask
  initial begin
    test_reset();
    test_static();
    test_decode();
    test_frame_latch();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
